// File: rtl/substitution_seq.sv
// Ascon S-box layer, COLS_PER_CYCLE columns per clock, chunked in place.
// Define ADD_CONST_FUSE_EN to fold the round-constant XOR into capture.
module substitution_seq #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [63:0] state_i [5],
`ifdef ADD_CONST_FUSE_EN
  input  logic [3:0]  round_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] state_o [5]
);

  localparam int N     = 64 / COLS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SUBST, DONE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      work_q [5];
  logic [63:0]      work_d [5];
  logic [63:0]      out_q [5];
  logic [63:0]      out_d [5];
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [63:0]      cap [5];
  logic [63:0]      sub [5];

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'h04;
      5'd1:  y = 5'h0B;
      5'd2:  y = 5'h1F;
      5'd3:  y = 5'h14;
      5'd4:  y = 5'h1A;
      5'd5:  y = 5'h15;
      5'd6:  y = 5'h09;
      5'd7:  y = 5'h02;
      5'd8:  y = 5'h1B;
      5'd9:  y = 5'h05;
      5'd10: y = 5'h08;
      5'd11: y = 5'h12;
      5'd12: y = 5'h1D;
      5'd13: y = 5'h03;
      5'd14: y = 5'h06;
      5'd15: y = 5'h1C;
      5'd16: y = 5'h1E;
      5'd17: y = 5'h13;
      5'd18: y = 5'h07;
      5'd19: y = 5'h0E;
      5'd20: y = 5'h00;
      5'd21: y = 5'h0D;
      5'd22: y = 5'h11;
      5'd23: y = 5'h18;
      5'd24: y = 5'h10;
      5'd25: y = 5'h0C;
      5'd26: y = 5'h01;
      5'd27: y = 5'h19;
      5'd28: y = 5'h16;
      5'd29: y = 5'h0A;
      5'd30: y = 5'h0F;
      default: y = 5'h17;
    endcase
    return y;
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) cap[i] = state_i[i];
`ifdef ADD_CONST_FUSE_EN
    cap[2][7:0] = state_i[2][7:0] ^ {4'd15 - round_i, round_i};
`endif
  end

  // lane 0 supplies the S-box input MSB
  always_comb begin
    logic [5:0] col;
    logic [4:0] x;
    logic [4:0] y;
    col = '0;
    x   = '0;
    y   = '0;
    for (int i = 0; i < 5; i++) sub[i] = work_q[i];
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col = 6'(int'(cnt_q) * COLS_PER_CYCLE + k);
      x = {work_q[0][col], work_q[1][col], work_q[2][col],
           work_q[3][col], work_q[4][col]};
      y = sbox(x);
      sub[0][col] = y[4];
      sub[1][col] = y[3];
      sub[2][col] = y[2];
      sub[3][col] = y[1];
      sub[4][col] = y[0];
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    out_d  = out_q;
    unique case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          work_d = cap;
          cnt_d  = '0;
          fsm_d  = SUBST;
        end else begin
          fsm_d = IDLE;
        end
      end
      SUBST: begin
        work_d = sub;
        if (cnt_q == LAST) begin
          out_d = sub;
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d == SUBST);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      work_q <= '{default: '0};
      out_q  <= '{default: '0};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign state_o = out_q;

endmodule

// File: tb/tb_substitution_seq.sv
// Bench for substitution_seq: vector table, scoreboard, reset/hold corners.
// Honors ADD_CONST_FUSE_EN when defined.
module tb_substitution_seq;

  localparam int COLS = 8;
  localparam int N    = 64 / COLS;

  typedef logic [4:0][63:0] st_t;

  typedef struct packed {
    st_t        st;
    logic [3:0] rnd;
    st_t        exp;
  } vec_t;

  localparam logic [7:0] SBOX [32] = '{
    8'h04, 8'h0B, 8'h1F, 8'h14, 8'h1A, 8'h15, 8'h09, 8'h02,
    8'h1B, 8'h05, 8'h08, 8'h12, 8'h1D, 8'h03, 8'h06, 8'h1C,
    8'h1E, 8'h13, 8'h07, 8'h0E, 8'h00, 8'h0D, 8'h11, 8'h18,
    8'h10, 8'h0C, 8'h01, 8'h19, 8'h16, 8'h0A, 8'h0F, 8'h17};

`ifdef ADD_CONST_FUSE_EN
  localparam logic [7:0] FUSE_MASK = 8'hFF;
`else
  localparam logic [7:0] FUSE_MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] st_i [5];
  logic [63:0] st_o [5];
`ifdef ADD_CONST_FUSE_EN
  logic [3:0]  rnd;
`endif

  int   tests = 0;
  int   fails = 0;
  st_t  sb [$];
  vec_t vt [6];

  always #5 clk = ~clk;

  substitution_seq #(.COLS_PER_CYCLE(COLS)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .start_i (start),
    .state_i (st_i),
`ifdef ADD_CONST_FUSE_EN
    .round_i (rnd),
`endif
    .busy_o  (busy),
    .done_o  (done),
    .state_o (st_o)
  );

  function automatic st_t model(input st_t s, input logic [3:0] r);
    st_t        t;
    logic [4:0] x;
    logic [7:0] y;
    t = s;
    t[2][7:0] = t[2][7:0] ^ ({4'd15 - r, r} & FUSE_MASK);
    for (int j = 0; j < 64; j++) begin
      x = {t[0][j], t[1][j], t[2][j], t[3][j], t[4][j]};
      y = SBOX[x];
      t[0][j] = y[4];
      t[1][j] = y[3];
      t[2][j] = y[2];
      t[3][j] = y[1];
      t[4][j] = y[0];
    end
    return t;
  endfunction

  function automatic st_t rand_st();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  function automatic st_t get_o();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = st_o[i];
    return s;
  endfunction

  task automatic set_i(input st_t s, input logic [3:0] r);
    for (int i = 0; i < 5; i++) st_i[i] = s[i];
`ifdef ADD_CONST_FUSE_EN
    rnd = r;
`else
    if (r > 4'd15) $display("unreachable");
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_v(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_s(input string nm, input st_t got, input st_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_one(input st_t s, input logic [3:0] r,
                         input st_t e, input string nm);
    int  c;
    st_t exp;
    set_i(s, r);
    start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    c = 1;
    check_v({nm, "_busy"}, int'(busy), 1);
    while (!done && c < N + 20) begin
      tick();
      c++;
    end
    exp = sb.pop_front();
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done_o after %0d cycles", nm, c);
    end else begin
      check_v({nm, "_lat"}, c, N + 1);
      check_v({nm, "_busy_done"}, int'(busy), 0);
      check_s(nm, get_o(), exp);
    end
    tick();
    check_v({nm, "_pulse"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t        s;
    st_t        last;
    logic [3:0] r;
    int         dn;

    vt[0].st  = '0;
    vt[0].rnd = 4'd0;
`ifdef ADD_CONST_FUSE_EN
    vt[0].exp[0] = 64'h00000000000000F0;
    vt[0].exp[1] = 64'h00000000000000F0;
    vt[0].exp[2] = 64'hFFFFFFFFFFFFFF0F;
    vt[0].exp[3] = 64'h00000000000000F0;
    vt[0].exp[4] = 64'h0;
`else
    vt[0].exp    = '0;
    vt[0].exp[2] = '1;
`endif
    vt[1].st  = '1;
    vt[1].rnd = 4'd3;
`ifdef ADD_CONST_FUSE_EN
    vt[1].exp = model(vt[1].st, vt[1].rnd);
`else
    vt[1].exp    = '1;
    vt[1].exp[1] = '0;
`endif
    for (int i = 2; i < 6; i++) begin
      vt[i].st  = rand_st();
      vt[i].rnd = 4'($urandom_range(0, 15));
      vt[i].exp = model(vt[i].st, vt[i].rnd);
    end

    rst   = 1'b1;
    start = 1'b0;
    set_i('0, 4'd0);
    tick();
    tick();
    check_v("rst_busy", int'(busy), 0);
    check_v("rst_done", int'(done), 0);
    check_s("rst_state", get_o(), '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_one(vt[i].st, vt[i].rnd, vt[i].exp, $sformatf("vec%0d", i));

    last = vt[5].exp;
    tick();
    tick();
    check_s("hold_idle", get_o(), last);

    // ignored starts in SUBST must not disturb the captured word
    s = rand_st();
    r = 4'd5;
    set_i(s, r);
    start = 1'b1;
    sb.push_back(model(s, r));
    tick();
    dn = 0;
    for (int k = 1; k <= N; k++) begin
      check_s("hold_mid", get_o(), last);
      set_i(rand_st(), 4'($urandom_range(0, 11)));
      if (done) dn++;
      tick();
    end
    start = 1'b0;
    check_v("ign_done", int'(done), 1);
    check_v("ign_early", dn, 0);
    check_s("ign_state", get_o(), sb.pop_front());
    tick();

    dn = 0;
    start = 1'b1;
    for (int k = 0; k < 3 * (N + 1); k++) begin
      s = rand_st();
      r = 4'($urandom_range(0, 11));
      set_i(s, r);
      if (k % (N + 1) == 0) sb.push_back(model(s, r));
      tick();
      check_v("b2b_done", int'(done), int'(k % (N + 1) == N));
      check_v("b2b_busy", int'(busy), int'(k % (N + 1) != N));
      if (done) begin
        dn++;
        if (sb.size() > 0) check_s("b2b_state", get_o(), sb.pop_front());
      end
    end
    start = 1'b0;
    check_v("b2b_count", dn, 3);
    check_v("b2b_sb_empty", sb.size(), 0);
    tick();
    check_v("b2b_idle", int'(busy), 0);

    s = rand_st();
    set_i(s, 4'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_v("abort_busy", int'(busy), 0);
    check_v("abort_done", int'(done), 0);
    check_s("abort_state", get_o(), '0);
    dn = 0;
    for (int k = 0; k < N + 3; k++) begin
      tick();
      if (done) dn++;
    end
    check_v("abort_no_done", dn, 0);
    s = rand_st();
    r = 4'd11;
    run_one(s, r, model(s, r), "after_abort");

    s = rand_st();
    r = 4'd14;
    run_one(s, r, model(s, r), "round14");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
